elec_cache_ctrl: RTL and testbench

Control stage that sits directly upstream of the 1024-bit electrode register cache. It turns decoded SPI word writes into cache write strobes and tracks which of the 64 cache words have been loaded. On an apply request it drives the cache `state` code that rotates the cache exactly one full revolution into the electrode chain, then issues a latch pulse. A full rotation leaves the cache contents unchanged, so the same pattern can be re-applied without rewriting.

---
 rtl/elec_cache_ctrl.sv | 131 +++++++++++++
 tb/tb_elec_cache_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elec_cache_ctrl.sv
// rtl/elec_cache_ctrl.sv - SPI word writes to cache strobes, load tracking and apply sequencing
// One apply rotates the cache exactly one revolution into the electrode chain, then latches.
module elec_cache_ctrl #(
  parameter int ADDR_LEN  = 6,
  parameter int DATA_LEN  = 16,
  parameter int NUM_WORDS = 64,
  parameter int CHAIN_LEN = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                apply_req,
  input  logic                apply_mode,
  output logic                write_cache_en,
  output logic [ADDR_LEN-1:0] addr,
  output logic [DATA_LEN-1:0] data_in,
  output logic [3:0]          state,
  output logic                chain_en,
  output logic                elec_latch,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam logic [3:0] CODE_IDLE  = 4'b0000;
  localparam logic [3:0] CODE_STIM  = 4'b0010;
  localparam logic [3:0] CODE_REC   = 4'b0100;
  localparam logic [3:0] CODE_LATCH = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DONE} fsm_t;

  fsm_t                 r_fsm;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_WORDS-1:0] r_mask;

  logic [NUM_WORDS-1:0] w_mask_next;
  logic [31:0]          w_addr_ext;
  logic                 w_idle;
  logic                 w_addr_ok;
  logic                 w_wr_ok;
  logic                 w_wr_rej;
  logic                 w_ap_ok;
  logic                 w_ap_rej;

  always_comb begin
    w_idle      = (r_fsm == S_IDLE);
    w_addr_ext  = 32'(wr_addr);
    w_addr_ok   = (w_addr_ext < 32'(NUM_WORDS));
    w_wr_ok     = wr_valid & w_idle & w_addr_ok;
    w_wr_rej    = wr_valid & ~w_wr_ok;
    // A same-cycle write wins over the apply so the write is never lost.
    w_ap_ok     = apply_req & w_idle & ready & ~wr_valid;
    w_ap_rej    = apply_req & ~w_ap_ok;
    w_mask_next = r_mask;
    if (w_wr_ok) begin
      w_mask_next[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm          <= S_IDLE;
      r_cnt          <= '0;
      r_mask         <= '0;
      write_cache_en <= 1'b0;
      addr           <= '0;
      data_in        <= '0;
      state          <= CODE_IDLE;
      chain_en       <= 1'b0;
      elec_latch     <= 1'b0;
      ready          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      write_cache_en <= w_wr_ok;
      if (w_wr_ok) begin
        addr    <= wr_addr;
        data_in <= wr_data;
      end
      r_mask     <= w_mask_next;
      ready      <= &w_mask_next;
      err        <= w_wr_rej | w_ap_rej;
      elec_latch <= 1'b0;
      done       <= 1'b0;

      case (r_fsm)
        S_IDLE: begin
          if (w_ap_ok) begin
            r_fsm    <= S_SHIFT;
            r_cnt    <= CNT_W'(CHAIN_LEN - 1);
            state    <= apply_mode ? CODE_REC : CODE_STIM;
            chain_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          // The state register itself holds the latched mode code for the whole rotation.
          if (r_cnt == '0) begin
            r_fsm      <= S_LATCH;
            state      <= CODE_LATCH;
            chain_en   <= 1'b0;
            elec_latch <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LATCH: begin
          r_fsm <= S_DONE;
          state <= CODE_IDLE;
          done  <= 1'b1;
        end
        S_DONE: begin
          r_fsm <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          r_fsm    <= S_IDLE;
          state    <= CODE_IDLE;
          chain_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elec_cache_ctrl.sv
// tb/tb_elec_cache_ctrl.sv - self-checking bench for elec_cache_ctrl
// Timeline reference model plus a rotating 1024-bit cache model for the serial stream.
module tb_elec_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        apply_req;
  logic        apply_mode;
  logic        write_cache_en;
  logic [5:0]  addr;
  logic [15:0] data_in;
  logic [3:0]  state;
  logic        chain_en;
  logic        elec_latch;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;

  elec_cache_ctrl dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .apply_req(apply_req), .apply_mode(apply_mode), .write_cache_en(write_cache_en),
    .addr(addr), .data_in(data_in), .state(state), .chain_en(chain_en),
    .elec_latch(elec_latch), .ready(ready), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  // Reference model: apply timeline measured from the accepting edge.
  int          ap_edge;
  bit          ap_mode;
  bit          m_mask[64];
  logic [15:0] m_mem[64];
  bit          m_ready;
  logic        x_wce, x_chain, x_latch, x_busy, x_done, x_err;
  logic [5:0]  x_addr;
  logic [15:0] x_data;
  logic [3:0]  x_state;

  function automatic int ph(int e);
    return e - ap_edge + 1;
  endfunction

  task automatic model_reset();
    foreach (m_mask[i]) m_mask[i] = 1'b0;
    ap_edge = -100000;
    ap_mode = 1'b0;
    m_ready = 1'b0;
    {x_wce, x_chain, x_latch, x_busy, x_done, x_err} = '0;
    x_addr  = '0;
    x_data  = '0;
    x_state = '0;
  endtask

  task automatic model_step(int e);
    int pp, p;
    bit idle, wok, aok;
    pp   = ph(e - 1);
    idle = (pp < 1) || (pp >= 1027);
    wok  = wr_valid && idle && (int'(wr_addr) < 64);
    aok  = apply_req && idle && m_ready && !wr_valid;
    x_err = (wr_valid && !wok) || (apply_req && !aok);
    x_wce = wok;
    if (wok) begin
      m_mask[wr_addr] = 1'b1;
      m_mem[wr_addr]  = wr_data;
      x_addr = wr_addr;
      x_data = wr_data;
    end
    m_ready = 1'b1;
    foreach (m_mask[i]) if (!m_mask[i]) m_ready = 1'b0;
    if (aok) begin
      ap_edge = e;
      ap_mode = apply_mode;
    end
    p = ph(e);
    x_state = (p >= 1 && p <= 1024) ? (ap_mode ? 4'b0100 : 4'b0010) :
              (p == 1025) ? 4'b1000 : 4'b0000;
    x_chain = (p >= 1 && p <= 1024);
    x_latch = (p == 1025);
    x_done  = (p == 1026);
    x_busy  = (p >= 1 && p <= 1026);
  endtask

  task automatic check_model();
    logic [32:0] act, exp;
    act = {write_cache_en, addr, data_in, state, chain_en, elec_latch, ready, busy, done, err};
    exp = {x_wce, x_addr, x_data, x_state, x_chain, x_latch, m_ready, x_busy, x_done, x_err};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL model edge %0d: got wce,addr,data,state,chain,latch,ready,busy,done,err=%h want %h",
                 edge_cnt, act, exp);
    end
  endtask

  task automatic check_zero(string nm);
    n_vec++;
    if ({write_cache_en, addr, data_in, state, chain_en, elec_latch, ready, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want 0", nm,
               {write_cache_en, addr, data_in, state, chain_en, elec_latch, ready, busy, done, err});
    end
  endtask

  task automatic tick();
    edge_cnt++;
    model_step(edge_cnt);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(bit wv, logic [5:0] wa, logic [15:0] wd, bit ar, bit am);
    wr_valid = wv; wr_addr = wa; wr_data = wd; apply_req = ar; apply_mode = am;
    tick();
    wr_valid = 1'b0; apply_req = 1'b0;
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 1200; i++) begin
      if (ph(edge_cnt) >= 1027) break;
      tick();
    end
  endtask

  // Cache model: rotates right one bit per shift cycle, serial output is bit 0.
  bit [1023:0] cache;
  bit [1023:0] cap_bits;
  int          cap_n = 0;
  bit          prev_shift = 1'b0;
  logic        is_shift;
  assign is_shift = (state == 4'b0010) || (state == 4'b0100);

  always @(posedge clk) begin
    prev_shift <= is_shift;
    if (is_shift) begin
      cap_bits[prev_shift ? cap_n : 0] <= cache[0];
      cap_n <= prev_shift ? cap_n + 1 : 1;
    end
    if (write_cache_en) cache[int'(addr)*16 +: 16] <= data_in;
    else if (is_shift)  cache <= {cache[0], cache[1023:1]};
  end

  task automatic check_capture(string nm);
    bit [1023:0] pat;
    for (int k = 0; k < 64; k++) pat[k*16 +: 16] = m_mem[k];
    n_vec++;
    if (cap_n != 1024 || cap_bits != pat) begin
      n_bad++;
      $display("FAIL %s serial: got %0d bits (first word %h) want 1024 bits (first word %h)",
               nm, cap_n, cap_bits[15:0], pat[15:0]);
    end
    n_vec++;
    if (cache != pat) begin
      n_bad++;
      $display("FAIL %s contents: got word0=%h word63=%h want word0=%h word63=%h",
               nm, cache[15:0], cache[1023:1008], pat[15:0], pat[1023:1008]);
    end
  endtask

  typedef struct {
    bit          wv;
    logic [5:0]  wa;
    logic [15:0] wd;
    bit          ar;
    bit          am;
    bit          x_wce;
    logic [5:0]  x_addr;
    logic [15:0] x_data;
    logic [3:0]  x_state;
    bit          x_busy;
    bit          x_err;
    bit          x_ready;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 6'd62, 16'hA53E, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 6'd63, 16'hA53F, 1'b1, 1'b0, 1'b1, 6'd63, 16'hA53F, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 6'd5,  16'h1234, 1'b0, 1'b0, 1'b1, 6'd5,  16'h1234, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 6'd9,  16'h9999, 1'b0, 1'b0, 1'b0, 6'd5,  16'h1234, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 6'd5,  16'h1234, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 6'd7,  16'hFFFF, 1'b0, 1'b0, 1'b0, 6'd5,  16'h1234, 4'b0010, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 6'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 6'd5,  16'h1234, 4'b0010, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 6'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 6'd5,  16'h1234, 4'b0010, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; apply_req = 1'b0; apply_mode = 1'b0;
    foreach (m_mem[i]) m_mem[i] = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Load words 0..62 only, then exercise the boundary cases from the table.
    for (int a = 0; a < 63; a++) drive(1'b1, 6'(a), 16'hA500 + 16'(a), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].ar, tbl[i].am);
      n_vec++;
      if ({write_cache_en, addr, data_in, state, busy, err, ready} !==
          {tbl[i].x_wce, tbl[i].x_addr, tbl[i].x_data, tbl[i].x_state, tbl[i].x_busy, tbl[i].x_err, tbl[i].x_ready}) begin
        n_bad++;
        $display("FAIL table[%0d]: got wce=%b addr=%h data=%h state=%b busy=%b err=%b ready=%b want wce=%b addr=%h data=%h state=%b busy=%b err=%b ready=%b",
                 i, write_cache_en, addr, data_in, state, busy, err, ready,
                 tbl[i].x_wce, tbl[i].x_addr, tbl[i].x_data, tbl[i].x_state, tbl[i].x_busy, tbl[i].x_err, tbl[i].x_ready);
      end
    end
    run_until_idle();
    check_capture("apply_stim");

    // Record-mode apply right away, with a write dropped mid-shift.
    drive(1'b0, 6'd0, 16'h0, 1'b1, 1'b1);
    repeat (9) tick();
    drive(1'b1, 6'd3, 16'hBEEF, 1'b0, 1'b0);
    run_until_idle();
    check_capture("apply_rec");

    // Reset at shift cycle 500, reload, re-apply.
    drive(1'b0, 6'd0, 16'h0, 1'b1, 1'b0);
    repeat (499) tick();
    rst = 1'b1;
    #1;
    check_zero("reset_mid_shift");
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 64; a++) drive(1'b1, 6'(a), 16'($urandom), 1'b0, 1'b0);
    drive(1'b0, 6'd0, 16'h0, 1'b1, 1'b0);
    run_until_idle();
    check_capture("apply_after_reset");

    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(3) == 0), 6'($urandom), 16'($urandom),
            ($urandom_range(99) == 0), 1'($urandom_range(1)));
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
